// File: rtl/saturn_bus_rom.sv
// saturn_bus_rom
//   Read-only memory slave on the Saturn nibble bus. It decodes bus command
//   nibbles, keeps independent PC and DP address pointers that are loaded
//   one nibble at a time, and returns one ROM nibble per data strobe while the
//   selected pointer lies inside [BASE_ADDR, BASE_ADDR + 2^DEPTH_LOG2).
//
//   Ports
//     i_clk            system clock
//     i_reset          synchronous active-high reset (highest priority)
//     i_bus_reset      bus-level synchronous reset from the bus controller
//     i_bus_clk_en     bus strobe; bus state only advances while high
//     i_bus_is_data    1 = data nibble, 0 = command nibble
//     i_bus_nibble_in  command/data nibble from the master
//     o_bus_nibble_out registered read nibble, held until the next strobe
//     o_bus_active     high while o_bus_nibble_out carries valid ROM data
//
//   Build option
//     SATURN_ROM_WRITE_EN : when defined, PC_WRITE/DP_WRITE data cycles that
//     hit the window store the nibble (patchable ROM for simulation).
//     When undefined the array is never written and maps to a ROM.
//
//   The array has no reset and no built-in loader: INIT_FILE names the
//   image that the integration flow (or the simulation harness) places
//   into mem.

module saturn_bus_rom #(
    parameter int              ADDR_W     = 20,
    parameter int              DEPTH_LOG2 = 20,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter string           INIT_FILE  = "rom-gx-r.hex"
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_bus_reset,
    input  logic       i_bus_clk_en,
    input  logic       i_bus_is_data,
    input  logic [3:0] i_bus_nibble_in,
    output logic [3:0] o_bus_nibble_out,
    output logic       o_bus_active
);

    localparam int NIBS  = ADDR_W / 4;
    localparam int CNT_W = $clog2(NIBS + 1);
    localparam logic [CNT_W-1:0] NIBS_C = CNT_W'(NIBS);

    // Window bounds carry one extra bit so a window ending at 2^ADDR_W
    // does not wrap around to zero.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + ((ADDR_W+1)'(1) << DEPTH_LOG2);

`ifdef SATURN_ROM_WRITE_EN
    localparam logic ROM_WR = 1'b1;
`else
    localparam logic ROM_WR = 1'b0;
`endif

    typedef enum logic [3:0] {
        CMD_NOP      = 4'h0,
        CMD_ID       = 4'h1,
        CMD_PC_READ  = 4'h2,
        CMD_DP_READ  = 4'h3,
        CMD_PC_WRITE = 4'h4,
        CMD_DP_WRITE = 4'h5,
        CMD_LOAD_PC  = 4'h6,
        CMD_LOAD_DP  = 4'h7,
        CMD_CONFIG   = 4'h8,
        CMD_UNCONFIG = 4'h9
    } cmd_t;

    logic [3:0]        mem [0:(1<<DEPTH_LOG2)-1];

    logic [ADDR_W-1:0] pc_ptr, dp_ptr, pc_nx, dp_nx;
    cmd_t              cmd, cmd_nx;
    logic [CNT_W-1:0]  nib_cnt, cnt_nx;
    logic [3:0]        out_q;
    logic              active, act_nx;
    logic              rd_hit, rd_miss, wr_hit, out_clr;

    logic              sel_pc, in_win;
    logic [ADDR_W-1:0] sel_ptr, offset;
    logic [DEPTH_LOG2-1:0] mem_addr;

    assign sel_pc   = (cmd == CMD_PC_READ) || (cmd == CMD_PC_WRITE);
    assign sel_ptr  = sel_pc ? pc_ptr : dp_ptr;
    assign in_win   = ({1'b0, sel_ptr} >= WIN_LO) && ({1'b0, sel_ptr} < WIN_HI);
    assign offset   = sel_ptr - BASE_ADDR;
    assign mem_addr = offset[DEPTH_LOG2-1:0];

    always_comb begin
        pc_nx   = pc_ptr;
        dp_nx   = dp_ptr;
        cmd_nx  = cmd;
        cnt_nx  = nib_cnt;
        act_nx  = active;
        rd_hit  = 1'b0;
        rd_miss = 1'b0;
        wr_hit  = 1'b0;
        out_clr = 1'b0;
        if (i_bus_clk_en) begin
            act_nx = 1'b0;
            if (!i_bus_is_data) begin
                cnt_nx = '0;
                case (i_bus_nibble_in)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8, 4'h9: cmd_nx = cmd_t'(i_bus_nibble_in);
                    // Bus RESET command behaves like i_bus_reset.
                    4'hF: begin
                        pc_nx   = '0;
                        dp_nx   = '0;
                        cmd_nx  = CMD_NOP;
                        out_clr = 1'b1;
                    end
                    default: cmd_nx = CMD_NOP;
                endcase
            end else begin
                case (cmd)
                    CMD_LOAD_PC: if (nib_cnt < NIBS_C) begin
                        pc_nx[{nib_cnt, 2'b00} +: 4] = i_bus_nibble_in;
                        cnt_nx = nib_cnt + CNT_W'(1);
                    end
                    CMD_LOAD_DP: if (nib_cnt < NIBS_C) begin
                        dp_nx[{nib_cnt, 2'b00} +: 4] = i_bus_nibble_in;
                        cnt_nx = nib_cnt + CNT_W'(1);
                    end
                    CMD_PC_READ, CMD_DP_READ, CMD_PC_WRITE, CMD_DP_WRITE: begin
                        if (cmd == CMD_PC_READ || cmd == CMD_DP_READ) begin
                            act_nx  = in_win;
                            rd_hit  = in_win;
                            rd_miss = !in_win;
                        end else begin
                            wr_hit  = in_win;
                        end
                        // Post-increment even out of window so every slave
                        // on the bus keeps the same pointer value.
                        if (sel_pc) pc_nx = pc_ptr + ADDR_W'(1);
                        else        dp_nx = dp_ptr + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_bus_reset) begin
            pc_ptr  <= '0;
            dp_ptr  <= '0;
            cmd     <= CMD_NOP;
            nib_cnt <= '0;
            out_q   <= '0;
            active  <= 1'b0;
        end else begin
            pc_ptr  <= pc_nx;
            dp_ptr  <= dp_nx;
            cmd     <= cmd_nx;
            nib_cnt <= cnt_nx;
            active  <= act_nx;
            if (rd_hit)
                out_q <= mem[mem_addr];
            else if (rd_miss || out_clr)
                out_q <= '0;
        end
    end

    // Constant-false ROM_WR lets synthesis drop the write port entirely.
    always_ff @(posedge i_clk) begin
        if (ROM_WR && wr_hit && !i_reset && !i_bus_reset)
            mem[mem_addr] <= i_bus_nibble_in;
    end

    assign o_bus_nibble_out = out_q;
    assign o_bus_active     = active;

endmodule

// File: tb/tb_saturn_bus_rom.sv
// Bench for saturn_bus_rom: a GX-sized instance (base 0, 1M nibbles) and a
// small instance (base 20'h80000, 16 nibbles) share one bus. Both arrays are
// preloaded with known patterns; a table of bus cycles drives the bus and the
// expected output of each cycle goes through a scoreboard queue.

module tb_saturn_bus_rom;

    logic       clk = 1'b0;
    logic       reset, bus_reset, clk_en, is_data;
    logic [3:0] nib_in;
    logic [3:0] out_g, out_s;
    logic       act_g, act_s;

    always #5 clk = ~clk;

    saturn_bus_rom #(.INIT_FILE("")) dut_gx (
        .i_clk(clk), .i_reset(reset), .i_bus_reset(bus_reset),
        .i_bus_clk_en(clk_en), .i_bus_is_data(is_data),
        .i_bus_nibble_in(nib_in), .o_bus_nibble_out(out_g), .o_bus_active(act_g)
    );

    saturn_bus_rom #(.DEPTH_LOG2(4), .BASE_ADDR(20'h80000), .INIT_FILE("")) dut_sm (
        .i_clk(clk), .i_reset(reset), .i_bus_reset(bus_reset),
        .i_bus_clk_en(clk_en), .i_bus_is_data(is_data),
        .i_bus_nibble_in(nib_in), .o_bus_nibble_out(out_s), .o_bus_active(act_s)
    );

    // chk: 0 = no check, 1 = active only, 2 = nibble and active
    typedef struct {
        logic       rst, brst, en, isd;
        logic [3:0] nib;
        logic [1:0] chk;
        logic       sel;   // 0 = gx instance, 1 = small instance
        logic [3:0] eo;
        logic       ea;
    } vec_t;

    typedef struct {
        logic [1:0] chk;
        logic       sel;
        logic [3:0] eo;
        logic       ea;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [3:0] gm(input logic [19:0] a);
        int s;
        s = int'(a[3:0]) + 3*int'(a[7:4]) + 5*int'(a[11:8]) +
            7*int'(a[15:12]) + 11*int'(a[19:16]) + 9;
        return s[3:0];
    endfunction

    function automatic logic [3:0] sm(input int i);
        int s;
        s = i*3 + 5;
        return s[3:0];
    endfunction

    function automatic void v(input logic rst, input logic brst, input logic en,
                              input logic isd, input logic [3:0] nib, input logic [1:0] chk,
                              input logic sel, input logic [3:0] eo, input logic ea);
        vec_t t;
        t.rst = rst; t.brst = brst; t.en = en; t.isd = isd; t.nib = nib;
        t.chk = chk; t.sel = sel; t.eo = eo; t.ea = ea;
        vecs.push_back(t);
    endfunction

    function automatic void cmd(input logic [3:0] c);
        v(0, 0, 1, 0, c, 2'd0, 0, 4'h0, 0);
    endfunction

    function automatic void dat(input logic [3:0] n);
        v(0, 0, 1, 1, n, 2'd0, 0, 4'h0, 0);
    endfunction

    function automatic void rd(input logic [3:0] eo, input logic ea);
        v(0, 0, 1, 1, 4'h0, 2'd2, 0, eo, ea);
    endfunction

    function automatic void srd(input logic [3:0] eo, input logic ea);
        v(0, 0, 1, 1, 4'h0, 2'd2, 1, eo, ea);
    endfunction

    function automatic void load(input logic [3:0] c, input logic [19:0] a);
        cmd(c);
        for (int k = 0; k < 5; k++) dat(a[4*k +: 4]);
    endfunction

    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        logic [3:0] ao;
        logic       aa;
        reset = t.rst; bus_reset = t.brst; clk_en = t.en;
        is_data = t.isd; nib_in = t.nib;
        e.chk = t.chk; e.sel = t.sel; e.eo = t.eo; e.ea = t.ea; e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk != 2'd0) begin
            ao = e.sel ? out_s : out_g;
            aa = e.sel ? act_s : act_g;
            n_vec++;
            if ((e.chk == 2'd2 && ao !== e.eo) || aa !== e.ea) begin
                n_bad++;
                $display("FAIL vec%0d %s: out=%h active=%b, expected out=%h active=%b",
                         e.idx, e.sel ? "small" : "gx", ao, aa, e.eo, e.ea);
            end
        end
    endtask

    logic [3:0] exp_patched;

    initial begin
        reset = 1'b0; bus_reset = 1'b0; clk_en = 1'b0; is_data = 1'b0; nib_in = 4'h0;

        for (int i = 0; i < (1 << 20); i++) dut_gx.mem[i] = gm(20'(i));
        for (int i = 0; i < 16; i++)        dut_sm.mem[i] = sm(i);

`ifdef SATURN_ROM_WRITE_EN
        exp_patched = 4'hA;
`else
        exp_patched = gm(20'h00010);
`endif

        // reset state on both instances
        v(1, 0, 1, 0, 4'h0, 2'd2, 0, 4'h0, 0);
        v(1, 0, 1, 0, 4'h0, 2'd2, 1, 4'h0, 0);
        // first read after reset: mem[0], then mem[1]
        v(0, 0, 1, 0, 4'h2, 2'd2, 0, 4'h0, 0);
        rd(gm(20'h0), 1);
        rd(gm(20'h1), 1);
        // LOAD_PC LSN first, extra nibble ignored
        load(4'h6, 20'h12345);
        dat(4'h7);
        cmd(4'h2);
        rd(gm(20'h12345), 1);
        rd(gm(20'h12346), 1);
        rd(gm(20'h12347), 1);
        // strobe low freezes output and pointers
        v(0, 0, 0, 1, 4'h9, 2'd2, 0, gm(20'h12347), 1);
        v(0, 0, 0, 0, 4'hF, 2'd2, 0, gm(20'h12347), 1);
        rd(gm(20'h12348), 1);
        // DP independent of PC
        load(4'h7, 20'h00010);
        cmd(4'h3);
        rd(gm(20'h00010), 1);
        cmd(4'h2);
        rd(gm(20'h12349), 1);
        // ID and an undefined code: data ignored, pointers untouched
        v(0, 0, 1, 0, 4'h1, 2'd1, 0, 4'h0, 0);
        v(0, 0, 1, 1, 4'h5, 2'd1, 0, 4'h0, 0);
        v(0, 0, 1, 0, 4'hC, 2'd1, 0, 4'h0, 0);
        v(0, 0, 1, 1, 4'h3, 2'd1, 0, 4'h0, 0);
        cmd(4'h2);
        rd(gm(20'h1234A), 1);
        // pointer wrap at all-ones
        load(4'h6, 20'hFFFFF);
        cmd(4'h2);
        rd(gm(20'hFFFFF), 1);
        rd(gm(20'h00000), 1);
        // write: pointer advances; memory patched only with the write option
        load(4'h7, 20'h00010);
        cmd(4'h5);
        v(0, 0, 1, 1, 4'hA, 2'd1, 0, 4'h0, 0);
        cmd(4'h3);
        rd(gm(20'h00011), 1);
        load(4'h7, 20'h00010);
        cmd(4'h3);
        rd(exp_patched, 1);
        // bus reset during LOAD_DP discards it and returns to NOP
        cmd(4'h7);
        dat(4'h3);
        dat(4'h4);
        v(0, 1, 1, 1, 4'h5, 2'd2, 0, 4'h0, 0);
        v(0, 0, 1, 1, 4'h6, 2'd2, 0, 4'h0, 0);
        cmd(4'h3);
        rd(gm(20'h0), 1);
        // new command mid-load keeps the partial nibbles
        v(1, 0, 0, 0, 4'h0, 2'd0, 0, 4'h0, 0);
        cmd(4'h6);
        dat(4'hA);
        dat(4'hB);
        cmd(4'h2);
        rd(gm(20'h000BA), 1);
        rd(gm(20'h000BB), 1);
        // bus RESET command clears output and pointers
        v(0, 0, 1, 0, 4'hF, 2'd2, 0, 4'h0, 0);
        cmd(4'h2);
        rd(gm(20'h0), 1);
        // small window: last nibble, above, below, first nibble
        load(4'h7, 20'h8000F);
        cmd(4'h3);
        srd(sm(15), 1);
        srd(4'h0, 0);
        load(4'h7, 20'h7FFFF);
        cmd(4'h3);
        srd(4'h0, 0);
        srd(sm(0), 1);
        // i_reset beats a simultaneous bus reset and command
        v(1, 1, 1, 0, 4'h6, 2'd2, 0, 4'h0, 0);
        v(0, 0, 1, 1, 4'h7, 2'd2, 0, 4'h0, 0);
        cmd(4'h2);
        rd(gm(20'h0), 1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Hand-written: long freeze with random bus noise while strobe is low.
        begin
            vec_t t;
            t.rst = 0; t.brst = 0; t.en = 1; t.isd = 1; t.nib = 4'h0;
            t.chk = 2'd2; t.sel = 0; t.eo = gm(20'h1); t.ea = 1;
            apply(t, 1000);
            for (int i = 0; i < 6; i++) begin
                t.en = 0; t.isd = 1'($urandom_range(0, 1));
                t.nib = 4'($urandom_range(0, 15));
                apply(t, 1001 + i);
            end
            t.en = 1; t.isd = 1; t.eo = gm(20'h2);
            apply(t, 1010);
        end

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
